sw_conditioner: RTL
===================

# sw_conditioner

Conditions the three raw game-control switches for the 60 Hz game logic and the beeper. Each switch is synchronised into the fast `clk` domain and debounced by a counter. Rising and falling events are held in pending flags. All outputs are republished only on the falling edge of the 60 Hz game clock, so they are stable across every rising edge at which game logic samples them.

## Interface
Parameters:
- `N_SW`, 3: number of switches conditioned.
- `DB_CYCLES`, 1_000_000: `clk` cycles a changed input must persist before it is accepted (10 ms at 100 MHz).
- `CNT_W`, `$clog2(DB_CYCLES+1)`: debounce counter width.

Ports:
- `clk` in 1: main 100 MHz clock.
- `rst_n_debounced` in 1: asynchronous, active-low reset.
- `game_clk` in 1: 60 Hz game clock, treated as an asynchronous data input.
- `sw_raw` in N_SW: raw switch pins, asynchronous.
- `sw_level` out N_SW: debounced level, frame-aligned.
- `sw_rise` out N_SW: at least one debounced 0→1 event occurred in the previous game period.
- `sw_fall` out N_SW: at least one debounced 1→0 event occurred in the previous game period.
- `frame_tick` out 1: one-`clk` pulse in the cycle in which the outputs update.

## Operation
- **Input sync:** each `sw_raw[i]` passes through 2 flops to give `s_sync[i]`. Flops reset to 0.
- **Debounce,** per switch, with internal state `stable[i]` (reset 0) and `cnt[i]` (reset 0). Each cycle:
  - if `s_sync==stable`: `cnt<=0`;
  - else if `cnt==DB_CYCLES-1`: `stable<=s_sync`, `cnt<=0`, and emit a 1-cycle event (rise if the new value is 1, fall if 0);
  - else `cnt<=cnt+1`.
  - A glitch shorter than `DB_CYCLES` cycles clears the counter and produces no event.
- **Pending flags:** `pend_rise[i]` and `pend_fall[i]` are set by events and cleared on transfer. Multiple same-direction events within one period collapse into one flag.
- **Game clock edge detect:** `game_clk` passes through `g1`→`g2`, then a delay flop `g3`; all reset to 0. Falling edge `gfall = g3 & ~g2`. Rising edges are ignored.
- **Transfer,** registered on a cycle where `gfall=1`:
  - `sw_rise <= pend_rise | ev_rise`;
  - `sw_fall <= pend_fall | ev_fall`;
  - `sw_level <= stable_next`;
  - pending flags are cleared, except that an event arriving in the same cycle is included in this transfer and not left pending;
  - `frame_tick <= 1`.
  - On all other cycles, `sw_*` hold and `frame_tick <= 0`.
- **Short press:** a press and release both accepted within one period gives `sw_rise=1`, `sw_fall=1` and `sw_level=0` in the same frame.
- **Hold duration:** `sw_rise` and `sw_fall` are held for exactly one game period and cleared at the next transfer unless refilled.
- **Reset:** all outputs are 0 after reset (`sw_level`, `sw_rise`, `sw_fall`, `frame_tick`). Reset mid-debounce discards counts and pending events. A switch that is held high through reset produces a rise after `DB_CYCLES+2` cycles.

## Timing
- `stable[i]` changes `DB_CYCLES+2` `clk` edges after the edge that first samples a changed `sw_raw[i]`.
- Outputs update on the 3rd `clk` edge after `game_clk` falls (edges 1–2 for sync, edge 3 to register). That is about 8.3 ms before the next game-clock rising edge, so game logic always sees settled data.
- Worst-case latency from an accepted event to `sw_rise` is one game period plus 3 cycles.
- `frame_tick` is high for exactly 1 cycle per game period.

## Configuration
- `SW_DEBOUNCE_EN`:
  - **Defined:** the debounce counter operates as described above.
  - **Undefined:** the counter is removed, `stable <= s_sync` every cycle, and an event is emitted on every change. Latency becomes 3 edges. This is intended for fast simulation; all other behaviour is unchanged.

## Test plan
Bench: `DB_CYCLES=8`, `SW_DEBOUNCE_EN` defined, `game_clk` period 200 `clk` cycles.
- **Clean press:** `sw_raw[0]` 0→1 held → `stable[0]` rises 10 edges later. At the next transfer, `sw_rise=3'b001` and `sw_level=3'b001`. One period later, `sw_rise=0` and `sw_level` stays `3'b001`.
- **Glitch:** `sw_raw[1]` high for 7 cycles then low → no event. `sw_rise`, `sw_fall` and `sw_level` stay 0 over 3 periods.
- **Short press:** `sw_raw[2]` high for 40 cycles inside one period → next transfer gives `sw_rise=3'b100`, `sw_fall=3'b100`, `sw_level=3'b000`.
- **Same-cycle collision:** time the event to coincide with `gfall` → the event appears in that transfer (`sw_rise=1`), and there is no repeat in the following frame.
- **Reset mid-operation:** assert `rst_n_debounced` low mid-count with a pending rise → all outputs 0 immediately. After release with `sw_raw=1`, exactly one rise is reported.
- **Frame tick:** over 5 periods, exactly 5 single-cycle `frame_tick` pulses occur, each 3 edges after a `game_clk` fall.

Source files
------------

// File: rtl/sw_conditioner.sv
// sw_conditioner: synchronise, debounce and frame-align game switches to the falling edge of game_clk.
// Define SW_DEBOUNCE_EN to enable the debounce counter; without it, synchronised inputs are accepted directly.
module sw_conditioner #(
    parameter int N_SW      = 3,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n_debounced,
    input  logic            game_clk,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            frame_tick
);
    logic [N_SW-1:0] s_meta, s_sync, stable, stable_next;
    logic [N_SW-1:0] ev_rise, ev_fall, pend_rise, pend_fall;
    logic            g1, g2, g3, gfall;

    always_ff @(posedge clk or negedge rst_n_debounced)
        if (!rst_n_debounced) begin
            s_meta <= '0;
            s_sync <= '0;
            g1     <= 1'b0;
            g2     <= 1'b0;
            g3     <= 1'b0;
        end else begin
            s_meta <= sw_raw;
            s_sync <= s_meta;
            g1     <= game_clk;
            g2     <= g1;
            g3     <= g2;
        end

`ifdef SW_DEBOUNCE_EN
    for (genvar i = 0; i < N_SW; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             done;
        assign done           = cnt == CNT_W'(DB_CYCLES - 1);
        assign stable_next[i] = (s_sync[i] != stable[i] && done) ? s_sync[i] : stable[i];
        always_ff @(posedge clk or negedge rst_n_debounced)
            if (!rst_n_debounced) cnt <= '0;
            else                  cnt <= (s_sync[i] == stable[i] || done) ? '0 : cnt + 1'b1;
    end
`else
    assign stable_next = s_sync;
`endif

    assign gfall   = g3 & ~g2;
    assign ev_rise = stable_next & ~stable;
    assign ev_fall = stable & ~stable_next;

    // Events landing on the transfer cycle go straight to the outputs, never into pending.
    always_ff @(posedge clk or negedge rst_n_debounced)
        if (!rst_n_debounced) begin
            stable     <= '0;
            pend_rise  <= '0;
            pend_fall  <= '0;
            sw_level   <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            frame_tick <= 1'b0;
        end else begin
            stable     <= stable_next;
            pend_rise  <= gfall ? '0 : pend_rise | ev_rise;
            pend_fall  <= gfall ? '0 : pend_fall | ev_fall;
            frame_tick <= gfall;
            if (gfall) begin
                sw_rise  <= pend_rise | ev_rise;
                sw_fall  <= pend_fall | ev_fall;
                sw_level <= stable_next;
            end
        end
endmodule
